// File: rtl/traffic_ctrl_rr.sv
// traffic_ctrl_rr: N-way traffic-light controller.
// Approaches take turns in round-robin order. Each turn runs GREEN -> YELLOW -> ALL_RED.
// Green time is bounded below by MIN_GREEN. When other approaches are waiting, it is also
// bounded above by MAX_GREEN. Lamp outputs decode registered state only.
module traffic_ctrl_rr #(
    parameter int NUM_DIR   = 4,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 8,
    parameter int YELLOW    = 2,
    parameter int CLEAR     = 1,
    parameter int CNT_W     = 8
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [NUM_DIR-1:0]         i_car,
    output logic [NUM_DIR-1:0]         o_green,
    output logic [NUM_DIR-1:0]         o_yellow,
    output logic [NUM_DIR-1:0]         o_red,
    output logic [$clog2(NUM_DIR)-1:0] o_active,
    output logic [1:0]                 o_phase
);

    localparam int AW = $clog2(NUM_DIR);

    // Last timer value of each phase. The timer is 0 in the first cycle of a phase.
    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'((CLEAR > 0) ? CLEAR - 1 : 0);
    localparam logic [CNT_W-1:0] TIMER_MAX = '1;

    typedef enum logic [1:0] {
        PH_GREEN   = 2'd0,
        PH_YELLOW  = 2'd1,
        PH_ALL_RED = 2'd2
    } phase_e;

    phase_e            phase_q, phase_d;
    logic [AW-1:0]     active_q, active_d;
    logic [AW-1:0]     next_q, next_d;
    logic [CNT_W-1:0]  timer_q, timer_d;

    logic [NUM_DIR-1:0] active_mask;
    logic [NUM_DIR-1:0] car_rot;
    logic               other_req;
    logic               active_req;
    logic               pick_found;
    logic [AW-1:0]      rr_pick;
    logic               green_done;

    // Request summary relative to the approach that currently owns the phase
    always_comb begin
        active_mask = NUM_DIR'(1) << active_q;
        other_req   = |(i_car & ~active_mask);
        active_req  = |(i_car & active_mask);
    end

    // Round-robin search: rotate requests so bit j means approach (active+j) mod NUM_DIR
    always_comb begin
        car_rot    = NUM_DIR'({i_car, i_car} >> active_q);
        pick_found = 1'b0;
        rr_pick    = active_q;
        for (int j = 0; j < NUM_DIR; j++) begin
            if (j > 0 && !pick_found && car_rot[j]) begin
                pick_found = 1'b1;
                rr_pick    = AW'((int'(active_q) + j) % NUM_DIR);
            end
        end
    end

    // Phase sequencing and timer next-state
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves it unassigned (no latch).
        phase_d    = phase_q;
        active_d   = active_q;
        next_d     = next_q;
        timer_d    = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
        green_done = (timer_q >= MIN_LAST) && other_req &&
                     (!active_req || timer_q >= MAX_LAST);

        case (phase_q)
            PH_GREEN: begin
                if (green_done) begin
                    phase_d = PH_YELLOW;
                    timer_d = '0;
                    next_d  = rr_pick;
                end
            end
            PH_YELLOW: begin
                if (timer_q == YEL_LAST) begin
                    timer_d = '0;
                    if (CLEAR > 0) begin
                        phase_d = PH_ALL_RED;
                    end else begin
                        phase_d  = PH_GREEN;
                        active_d = next_q;
                    end
                end
            end
            PH_ALL_RED: begin
                if (timer_q == CLR_LAST) begin
                    phase_d  = PH_GREEN;
                    active_d = next_q;
                    timer_d  = '0;
                end
            end
            default: begin
                phase_d = PH_GREEN;
                timer_d = '0;
            end
        endcase
    end

    // State register with synchronous reset that overrides any phase
    always_ff @(posedge i_clock) begin
        // NOTE: non-blocking assignments, so every register samples the pre-edge values.
        if (i_reset) begin
            phase_q  <= PH_GREEN;
            active_q <= '0;
            next_q   <= '0;
            timer_q  <= '0;
        end else begin
            phase_q  <= phase_d;
            active_q <= active_d;
            next_q   <= next_d;
            timer_q  <= timer_d;
        end
    end

    // Lamp decode from registered phase/active only
    always_comb begin
        o_green  = (phase_q == PH_GREEN)  ? active_mask : '0;
        o_yellow = (phase_q == PH_YELLOW) ? active_mask : '0;
        o_red    = ~(o_green | o_yellow);
        o_active = active_q;
        o_phase  = phase_q;
    end

endmodule
